// File: rtl/router_pkt_tx.sv
`default_nettype none
// ============================================================================
//  Module   : router_pkt_tx
//  Purpose  : Packet source for the input port of the 1x3 router. The host
//             fills a byte buffer, then issues start with a destination and
//             length. The block sends header {len,dest}, then the payload,
//             then an XOR parity byte. It honours the router busy
//             back-pressure and watches the router error flag for ERR_WAIT
//             cycles after the parity byte.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock     in   1  system clock, rising edge
//    resetn    in   1  asynchronous active-low reset
//    wr_en     in   1  host write strobe into the payload buffer
//    wr_data   in   8  payload byte, written at wr_count
//    clr       in   1  synchronous clear of the buffer write pointer
//    start     in   1  launch a packet (sampled in IDLE only)
//    dest      in   2  destination address, 0..2 valid
//    len       in   6  payload length, 1..MAX_LEN valid
//    busy      in   1  router back-pressure
//    error     in   1  router parity error flag
//    data_out  out  8  byte to the router data_in
//    pkt_valid out  1  to the router pkt_valid
//    tx_busy   out  1  high whenever the FSM is not idle
//    done      out  1  one-cycle pulse at the end of a packet
//    err_seen  out  1  valid with done: error seen in the check window
//    reject    out  1  one-cycle pulse when start is refused
//    wr_count  out  6  bytes currently held in the buffer
// ============================================================================
module router_pkt_tx #(
    parameter int MAX_LEN  = 63,
    parameter int ERR_WAIT = 3      // must be >= 1
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       clr,
    input  logic       start,
    input  logic [1:0] dest,
    input  logic [5:0] len,
    input  logic       busy,
    input  logic       error,
    output logic [7:0] data_out,
    output logic       pkt_valid,
    output logic       tx_busy,
    output logic       done,
    output logic       err_seen,
    output logic       reject,
    output logic [5:0] wr_count
);

    localparam int              CNT_W      = (ERR_WAIT < 2) ? 1 : $clog2(ERR_WAIT + 1);
    localparam logic [5:0]      C_MAX_LEN  = 6'(MAX_LEN);
    localparam logic [CNT_W-1:0] C_ERR_WAIT = CNT_W'(ERR_WAIT);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_PAYLOAD = 3'd2,
        S_PARITY  = 3'd3,
        S_ERRCHK  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t           state_q,    state_d;
    logic [5:0]       wr_count_q, wr_count_d;
    logic [5:0]       rd_ptr_q,   rd_ptr_d;
    logic [1:0]       dest_q,     dest_d;
    logic [5:0]       len_q,      len_d;
    logic [7:0]       parity_q,   parity_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             flag_q,     flag_d;
    logic             reject_q,   reject_d;

    // Payload store: not reset, only the write pointer is.
    logic [7:0]       mem_q [0:63];

    logic             wr_fire;
    logic             xfer;
    logic [7:0]       rd_byte;

    assign rd_byte = mem_q[rd_ptr_q];

    // A byte leaves on any edge where the router is not busy and a framed
    // byte is being presented.
    assign xfer = !busy && ((state_q == S_HEADER) || (state_q == S_PAYLOAD) ||
                            (state_q == S_PARITY));

    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        rd_ptr_d   = rd_ptr_q;
        dest_d     = dest_q;
        len_d      = len_q;
        parity_d   = parity_q;
        cnt_d      = cnt_q;
        flag_d     = flag_q;
        reject_d   = 1'b0;
        wr_fire    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (clr) begin
                    wr_count_d = 6'd0;
                end else if (wr_en && (wr_count_q != C_MAX_LEN)) begin
                    wr_fire    = 1'b1;
                    wr_count_d = wr_count_q + 6'd1;
                end
                if (start) begin
                    if ((dest == 2'd3) || (len == 6'd0) || (len > wr_count_q)) begin
                        reject_d = 1'b1;
                    end else begin
                        dest_d   = dest;
                        len_d    = len;
                        rd_ptr_d = 6'd0;
                        state_d  = S_HEADER;
                    end
                end
            end
            S_HEADER: begin
                if (xfer) begin
                    parity_d = {len_q, dest_q};
                    state_d  = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (xfer) begin
                    parity_d = parity_q ^ rd_byte;
                    rd_ptr_d = rd_ptr_q + 6'd1;
                    if (rd_ptr_q == (len_q - 6'd1)) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (xfer) begin
                    cnt_d   = C_ERR_WAIT;
                    flag_d  = 1'b0;
                    state_d = S_ERRCHK;
                end
            end
            S_ERRCHK: begin
                // Window is exactly ERR_WAIT cycles; leave when the count
                // would reach zero.
                if (error) begin
                    flag_d = 1'b1;
                end
                cnt_d = cnt_q - C_CNT_ONE;
                if (cnt_q <= C_CNT_ONE) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                wr_count_d = 6'd0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            wr_count_q <= 6'd0;
            rd_ptr_q   <= 6'd0;
            dest_q     <= 2'd0;
            len_q      <= 6'd0;
            parity_q   <= 8'd0;
            cnt_q      <= '0;
            flag_q     <= 1'b0;
            reject_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_count_q <= wr_count_d;
            rd_ptr_q   <= rd_ptr_d;
            dest_q     <= dest_d;
            len_q      <= len_d;
            parity_q   <= parity_d;
            cnt_q      <= cnt_d;
            flag_q     <= flag_d;
            reject_q   <= reject_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_fire) begin
            mem_q[wr_count_q] <= wr_data;
        end
    end

    // Outputs decode straight from registered state so a reset forces
    // pkt_valid low without waiting for a clock edge.
    always_comb begin
        data_out = 8'd0;
        case (state_q)
            S_HEADER:  data_out = {len_q, dest_q};
            S_PAYLOAD: data_out = rd_byte;
            S_PARITY:  data_out = parity_q;
            default:   data_out = 8'd0;
        endcase
    end

    assign pkt_valid = (state_q == S_HEADER) || (state_q == S_PAYLOAD);
    assign tx_busy   = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err_seen  = (state_q == S_DONE) && flag_q;
    assign reject    = reject_q;
    assign wr_count  = wr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_router_pkt_tx
//  Purpose  : Self-checking bench for router_pkt_tx. Keeps the payload as a
//             byte queue, builds each expected frame (header, payload, XOR
//             parity) and compares every cycle of the transfer, the error
//             window, done/err_seen, rejects, buffer limits and reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_router_pkt_tx;

    localparam int MAX_LEN  = 63;
    localparam int ERR_WAIT = 3;

    logic       clock = 1'b0;
    logic       resetn;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr;
    logic       start;
    logic [1:0] dest;
    logic [5:0] len;
    logic       busy;
    logic       error;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       tx_busy;
    logic       done;
    logic       err_seen;
    logic       reject;
    logic [5:0] wr_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] model_buf[$];

    router_pkt_tx #(.MAX_LEN(MAX_LEN), .ERR_WAIT(ERR_WAIT)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .clr       (clr),
        .start     (start),
        .dest      (dest),
        .len       (len),
        .busy      (busy),
        .error     (error),
        .data_out  (data_out),
        .pkt_valid (pkt_valid),
        .tx_busy   (tx_busy),
        .done      (done),
        .err_seen  (err_seen),
        .reject    (reject),
        .wr_count  (wr_count)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // All tasks are entered and left at a falling edge.
    task automatic load_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clock);
        wr_en = 1'b0;
        if (model_buf.size() < MAX_LEN) model_buf.push_back(b);
    endtask

    task automatic load_rand(input int n);
        for (int i = 0; i < n; i++) load_byte(8'($urandom));
    endtask

    task automatic try_reject(input logic [1:0] d, input logic [5:0] l);
        start = 1'b1;
        dest  = d;
        len   = l;
        @(negedge clock);
        start = 1'b0;
        check_val("reject_pulse", reject, 1);
        check_val("reject_pkt_valid", pkt_valid, 0);
        check_val("reject_tx_busy", tx_busy, 0);
        @(negedge clock);
        check_val("reject_clear", reject, 0);
        check_val("reject_idle", tx_busy, 0);
    endtask

    // busy_mode: 0 never busy, 1 random busy, 2 busy for two header cycles
    // err_mode : 0 none, 1 random in window, 2 on window cycle 2,
    //            3 random during the frame only (must be ignored)
    task automatic send_packet(input logic [1:0] d, input logic [5:0] l,
                               input int busy_mode, input int err_mode);
        logic [7:0] exp_bytes[$];
        logic [7:0] par;
        logic       exp_err;
        logic       e;
        int         n;
        int         idx;
        int         cyc;

        par = {l, d};
        exp_bytes.push_back(par);
        for (int i = 0; i < int'(l); i++) begin
            exp_bytes.push_back(model_buf[i]);
            par = par ^ model_buf[i];
        end
        exp_bytes.push_back(par);
        n       = int'(l) + 2;
        idx     = 0;
        cyc     = 0;
        exp_err = 1'b0;

        start = 1'b1;
        dest  = d;
        len   = l;
        @(negedge clock);
        start = 1'b0;

        while (idx < n && cyc < 2000) begin
            check_val("data_out", data_out, exp_bytes[idx]);
            check_val("pkt_valid", pkt_valid, (idx < n - 1));
            check_val("tx_busy", tx_busy, 1);
            check_val("no_reject", reject, 0);
            check_val("no_done", done, 0);
            case (busy_mode)
                1:       busy = 1'($urandom_range(0, 2) == 0);
                2:       busy = (cyc < 2);
                default: busy = 1'b0;
            endcase
            error = (err_mode == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            start = 1'($urandom_range(0, 1));
            @(negedge clock);
            if (!busy) idx++;
            cyc++;
        end
        check_val("xfer_budget", (idx == n), 1);
        busy  = 1'b0;
        start = 1'b0;

        for (int k = 1; k <= ERR_WAIT; k++) begin
            check_val("win_done", done, 0);
            check_val("win_pkt_valid", pkt_valid, 0);
            check_val("win_data_out", data_out, 0);
            check_val("win_tx_busy", tx_busy, 1);
            case (err_mode)
                1:       e = 1'($urandom_range(0, 1));
                2:       e = (k == 2);
                default: e = 1'b0;
            endcase
            error   = e;
            exp_err = exp_err | e;
            @(negedge clock);
        end
        error = 1'b0;
        check_val("done_pulse", done, 1);
        check_val("err_seen", err_seen, exp_err);
        check_val("done_pkt_valid", pkt_valid, 0);
        @(negedge clock);
        check_val("post_done", done, 0);
        check_val("post_tx_busy", tx_busy, 0);
        check_val("post_wr_count", wr_count, 0);
        check_val("post_err_seen", err_seen, 0);
        model_buf.delete();
    endtask

    initial begin
        resetn  = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'd0;
        clr     = 1'b0;
        start   = 1'b0;
        dest    = 2'd0;
        len     = 6'd0;
        busy    = 1'b0;
        error   = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check_val("rst_data_out", data_out, 0);
        check_val("rst_pkt_valid", pkt_valid, 0);
        check_val("rst_tx_busy", tx_busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err_seen", err_seen, 0);
        check_val("rst_reject", reject, 0);
        check_val("rst_wr_count", wr_count, 0);
        resetn = 1'b1;
        @(negedge clock);

        // Basic frame, no back-pressure: 0D AA 55 0F then FD
        load_byte(8'hAA);
        load_byte(8'h55);
        load_byte(8'h0F);
        check_val("wr_count3", wr_count, 3);
        send_packet(2'd1, 6'd3, 0, 0);

        // Same frame with the router busy over the header
        load_byte(8'hAA);
        load_byte(8'h55);
        load_byte(8'h0F);
        send_packet(2'd1, 6'd3, 2, 0);

        // Refused starts leave the buffer intact
        load_byte(8'hAA);
        load_byte(8'h55);
        load_byte(8'h0F);
        try_reject(2'd1, 6'd0);
        try_reject(2'd3, 6'd3);
        try_reject(2'd1, 6'd5);
        check_val("wr_count_after_reject", wr_count, 3);
        send_packet(2'd1, 6'd3, 0, 2);

        // Error only during the frame is ignored
        load_rand(3);
        send_packet(2'd2, 6'd3, 1, 3);

        // clr wins over a simultaneous write
        load_rand(4);
        clr   = 1'b1;
        wr_en = 1'b1;
        @(negedge clock);
        clr   = 1'b0;
        wr_en = 1'b0;
        model_buf.delete();
        check_val("clr_wr_count", wr_count, 0);

        // Full buffer, overflow write, maximum length frame
        load_rand(63);
        check_val("full_wr_count", wr_count, 63);
        load_byte(8'h5A);
        check_val("overflow_wr_count", wr_count, 63);
        send_packet(2'd0, 6'd63, 1, 1);

        // Random traffic
        for (int p = 0; p < 8; p++) begin
            int l;
            l = $urandom_range(1, 20);
            load_rand(l);
            send_packet(2'($urandom_range(0, 2)), 6'(l), 1, $urandom_range(0, 3));
        end

        // Asynchronous reset in the middle of the payload
        load_rand(6);
        start = 1'b1;
        dest  = 2'd2;
        len   = 6'd6;
        @(negedge clock);
        start = 1'b0;
        busy  = 1'b0;
        repeat (3) @(negedge clock);
        check_val("mid_pkt_valid", pkt_valid, 1);
        #2;
        resetn = 1'b0;
        #1;
        check_val("arst_pkt_valid", pkt_valid, 0);
        check_val("arst_wr_count", wr_count, 0);
        check_val("arst_tx_busy", tx_busy, 0);
        check_val("arst_data_out", data_out, 0);
        @(negedge clock);
        resetn = 1'b1;
        model_buf.delete();
        @(negedge clock);
        load_rand(5);
        send_packet(2'd1, 6'd5, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
